// File: rtl/mac_feed_ctrl.sv
// mac_feed_ctrl
//   Feeds signed 8-bit operand pairs from a valid/ready stream into an
//   external two-stage multiply-accumulate block. Captures the dot product
//   once the last pair has passed through the MAC, and presents it on a
//   valid/ready result port. A vector ends on in_last or on its 7th pair.
//
// Ports
//   clk, aclr              clock, asynchronous active-high reset (shared with MAC)
//   in_valid/in_ready      operand-pair handshake
//   in_a, in_b, in_last    signed operands, end-of-vector marker
//   mac_dataa, mac_datab   operands to the MAC (0 when no pair is accepted)
//   mac_sload, mac_clken   MAC load-new-sum and clock enable
//   mac_result             MAC accumulator output
//   out_valid/out_ready    result handshake
//   out_data               captured dot product
//   out_count              number of pairs in the captured vector (1..7)
//   out_trunc              vector was closed by the length limit, not by in_last

module mac_feed_ctrl (
    input  logic               clk,
    input  logic               aclr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  in_a,
    input  logic signed [7:0]  in_b,
    input  logic               in_last,
    output logic signed [7:0]  mac_dataa,
    output logic signed [7:0]  mac_datab,
    output logic               mac_sload,
    output logic               mac_clken,
    input  logic signed [17:0] mac_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [17:0] out_data,
    output logic [2:0]         out_count,
    output logic               out_trunc
);

    logic       accept;
    logic       first;
    logic       at_limit;
    logic       eff_last;
    logic       t1_valid;
    logic       t1_last;
    logic       cap_pend;
    logic [2:0] cnt;
    logic [2:0] vec_count;
    logic       vec_trunc;

    // cnt counts pairs already accepted in the open vector; 6 means the
    // incoming pair is the 7th and must close the vector.
    assign at_limit = (cnt == 3'd6);
    assign first    = (cnt == 3'd0);
    assign eff_last = in_last | at_limit;

    // Stall input from the moment the last pair is accepted until the result
    // has been handed off, so the MAC sum is never disturbed before capture.
    assign in_ready = ~aclr & ~out_valid & ~t1_last & ~cap_pend;
    assign accept   = in_valid & in_ready;

    assign mac_dataa = accept ? in_a : 8'sd0;
    assign mac_datab = accept ? in_b : 8'sd0;
    assign mac_sload = accept & first;
    // t1_valid keeps the MAC clocked one extra edge so the last registered
    // product reaches the accumulator; the operands then are 0/0.
    assign mac_clken = ~aclr & (accept | t1_valid);

    // Tag stage mirroring the MAC input register, pair counter, and the
    // count/trunc attributes of the vector that has just been closed.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            t1_valid  <= 1'b0;
            t1_last   <= 1'b0;
            cap_pend  <= 1'b0;
            cnt       <= 3'd0;
            vec_count <= 3'd0;
            vec_trunc <= 1'b0;
        end else begin
            if (mac_clken) begin
                t1_valid <= accept;
                t1_last  <= accept & eff_last;
            end

            // Last product enters the accumulator on this edge; sample the
            // sum on the following one.
            if (mac_clken && t1_last)
                cap_pend <= 1'b1;
            else if (cap_pend)
                cap_pend <= 1'b0;

            if (accept) begin
                if (eff_last) begin
                    cnt       <= 3'd0;
                    vec_count <= cnt + 3'd1;
                    vec_trunc <= at_limit & ~in_last;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end

    // Result register: loads once per vector, holds while out_ready is low.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            out_valid <= 1'b0;
            out_data  <= 18'sd0;
            out_count <= 3'd0;
            out_trunc <= 1'b0;
        end else begin
            if (cap_pend) begin
                out_valid <= 1'b1;
                out_data  <= mac_result;
                out_count <= vec_count;
                out_trunc <= vec_trunc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_feed_ctrl.sv
// Directed bench for mac_feed_ctrl with a behavioural two-stage MAC
// (input register, then accumulator) standing in for the downstream block.

module tb_mac_feed_ctrl;

    logic               clk;
    logic               aclr;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_a;
    logic signed [7:0]  in_b;
    logic               in_last;
    logic signed [7:0]  mac_dataa;
    logic signed [7:0]  mac_datab;
    logic               mac_sload;
    logic               mac_clken;
    logic signed [17:0] mac_result;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_data;
    logic [2:0]         out_count;
    logic               out_trunc;

    int n_cmp;
    int n_err;

    mac_feed_ctrl dut (
        .clk        (clk),
        .aclr       (aclr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_last    (in_last),
        .mac_dataa  (mac_dataa),
        .mac_datab  (mac_datab),
        .mac_sload  (mac_sload),
        .mac_clken  (mac_clken),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_trunc  (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream MAC model: operands registered on one enabled edge, summed
    // into the accumulator on the next enabled edge.
    logic signed [7:0]  ra, rb;
    logic               rsl;
    logic signed [15:0] prod;
    logic signed [17:0] acc;
    assign prod       = ra * rb;
    assign mac_result = acc;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ra  <= '0;
            rb  <= '0;
            rsl <= 1'b0;
            acc <= '0;
        end else if (mac_clken) begin
            ra  <= mac_dataa;
            rb  <= mac_datab;
            rsl <= mac_sload;
            acc <= rsl ? {{2{prod[15]}}, prod} : acc + {{2{prod[15]}}, prod};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        aclr = 1'b1; in_valid = 1'b1; in_a = 8'sd9; in_b = 8'sd9; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (mac_clken !== 1'b0) begin n_err++; $display("FAIL rst_clken: got %b want 0", mac_clken); end
        n_cmp++; if (mac_sload !== 1'b0) begin n_err++; $display("FAIL rst_sload: got %b want 0", mac_sload); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 18'sd0) begin n_err++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        n_cmp++; if (out_count !== 3'd0) begin n_err++; $display("FAIL rst_out_count: got %0d want 0", out_count); end
        n_cmp++; if (out_trunc !== 1'b0) begin n_err++; $display("FAIL rst_out_trunc: got %b want 0", out_trunc); end
        in_valid = 1'b0;
        aclr = 1'b0;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    // (3,4),(-2,5),(7,7 last): 12 - 10 + 49 = 51
    task automatic test_basic();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'sd3; in_b = 8'sd4; in_last = 1'b0;
        #1;
        n_cmp++; if (mac_sload !== 1'b1) begin n_err++; $display("FAIL basic_sload_first: got %b want 1", mac_sload); end
        n_cmp++; if (mac_dataa !== 8'sd3) begin n_err++; $display("FAIL basic_dataa: got %0d want 3", mac_dataa); end
        tick();
        in_a = -8'sd2; in_b = 8'sd5;
        #1;
        n_cmp++; if (mac_sload !== 1'b0) begin n_err++; $display("FAIL basic_sload_mid: got %b want 0", mac_sload); end
        n_cmp++; if (mac_datab !== 8'sd5) begin n_err++; $display("FAIL basic_datab: got %0d want 5", mac_datab); end
        tick();
        in_a = 8'sd7; in_b = 8'sd7; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_t1: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_e0: got %b want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_e1: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_ready_pend: got %b want 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid_e2: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 18'sd51) begin n_err++; $display("FAIL basic_data: got %0d want 51", out_data); end
        n_cmp++; if (out_count !== 3'd3) begin n_err++; $display("FAIL basic_count: got %0d want 3", out_count); end
        n_cmp++; if (out_trunc !== 1'b0) begin n_err++; $display("FAIL basic_trunc: got %b want 0", out_trunc); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_clear: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
    endtask

    // 7 x (-128,-128), no in_last: 7 * 16384 = 114688, truncated
    task automatic test_trunc();
        out_ready = 1'b0;
        in_a = -8'sd128; in_b = -8'sd128; in_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            #1;
            n_cmp++; if (mac_sload !== ((i == 0) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL trunc_sload[%0d]: got %b want %b", i, mac_sload, (i == 0)); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL trunc_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL trunc_ready_after7: got %b want 0", in_ready); end
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL trunc_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 18'sd114688) begin n_err++; $display("FAIL trunc_data: got %0d want 114688", out_data); end
        n_cmp++; if (out_count !== 3'd7) begin n_err++; $display("FAIL trunc_count: got %0d want 7", out_count); end
        n_cmp++; if (out_trunc !== 1'b1) begin n_err++; $display("FAIL trunc_flag: got %b want 1", out_trunc); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'sd1; in_b = 8'sd2; in_last = 1'b1;
        tick();
        #1;
        n_cmp++; if (mac_sload !== 1'b1) begin n_err++; $display("FAIL trunc_next_sload: got %b want 1", mac_sload); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick(); tick();
        n_cmp++; if (out_data !== 18'sd2) begin n_err++; $display("FAIL trunc_next_data: got %0d want 2", out_data); end
        n_cmp++; if (out_trunc !== 1'b0) begin n_err++; $display("FAIL trunc_next_flag: got %b want 0", out_trunc); end
        tick();
    endtask

    // (5,5), 3 idle cycles, (-1,10 last): 25 - 10 = 15
    task automatic test_gap();
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'sd5; in_b = 8'sd5; in_last = 1'b0;
        tick();
        in_valid = 1'b0; in_a = 8'sd99; in_b = 8'sd99;
        #1;
        n_cmp++; if (mac_clken !== 1'b1) begin n_err++; $display("FAIL gap_clken_t1: got %b want 1", mac_clken); end
        n_cmp++; if (mac_dataa !== 8'sd0) begin n_err++; $display("FAIL gap_dataa_zero: got %0d want 0", mac_dataa); end
        tick();
        n_cmp++; if (mac_clken !== 1'b0) begin n_err++; $display("FAIL gap_clken_idle1: got %b want 0", mac_clken); end
        tick();
        n_cmp++; if (mac_clken !== 1'b0) begin n_err++; $display("FAIL gap_clken_idle2: got %b want 0", mac_clken); end
        tick();
        in_valid = 1'b1; in_a = -8'sd1; in_b = 8'sd10; in_last = 1'b1;
        #1;
        n_cmp++; if (mac_sload !== 1'b0) begin n_err++; $display("FAIL gap_sload_resume: got %b want 0", mac_sload); end
        n_cmp++; if (mac_clken !== 1'b1) begin n_err++; $display("FAIL gap_clken_resume: got %b want 1", mac_clken); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 18'sd15) begin n_err++; $display("FAIL gap_data: got %0d want 15", out_data); end
        n_cmp++; if (out_count !== 3'd2) begin n_err++; $display("FAIL gap_count: got %0d want 2", out_count); end
    endtask

    // Result from test_gap held under out_ready=0 for 10 cycles, then (1,1 last)
    task automatic test_backpressure();
        in_valid = 1'b1; in_a = 8'sd1; in_b = 8'sd1; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if (out_data !== 18'sd15) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want 15", i, out_data); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_clear: got %b want 0", out_valid); end
        n_cmp++; if (mac_sload !== 1'b1) begin n_err++; $display("FAIL bp_next_sload: got %b want 1", mac_sload); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 18'sd1) begin n_err++; $display("FAIL bp_next_data: got %0d want 1", out_data); end
        n_cmp++; if (out_count !== 3'd1) begin n_err++; $display("FAIL bp_next_count: got %0d want 1", out_count); end
        tick();
    endtask

    // Two pairs, then aclr; fresh vector (2,-3 last) = -6
    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'sd4; in_b = 8'sd4; in_last = 1'b0;
        tick();
        in_a = 8'sd3; in_b = 8'sd3;
        tick();
        aclr = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
        n_cmp++; if (mac_clken !== 1'b0) begin n_err++; $display("FAIL rmid_clken: got %b want 0", mac_clken); end
        n_cmp++; if (mac_sload !== 1'b0) begin n_err++; $display("FAIL rmid_sload: got %b want 0", mac_sload); end
        n_cmp++; if (out_data !== 18'sd0) begin n_err++; $display("FAIL rmid_data: got %0d want 0", out_data); end
        n_cmp++; if (out_count !== 3'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", out_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        tick();
        aclr = 1'b0;
        in_a = 8'sd2; in_b = -8'sd3; in_last = 1'b1;
        #1;
        n_cmp++; if (mac_sload !== 1'b1) begin n_err++; $display("FAIL rmid_new_sload: got %b want 1", mac_sload); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rmid_new_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== -18'sd6) begin n_err++; $display("FAIL rmid_new_data: got %0d want -6", out_data); end
        n_cmp++; if (out_count !== 3'd1) begin n_err++; $display("FAIL rmid_new_count: got %0d want 1", out_count); end
        n_cmp++; if (out_trunc !== 1'b0) begin n_err++; $display("FAIL rmid_new_trunc: got %b want 0", out_trunc); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        aclr = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_trunc();
        test_gap();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_feed_ctrl.md
MAC_FEED_CTRL -- requirements
Module: mac_feed_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed: operands 8 bit signed, result 18 bit signed, maximum vector length 7.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 aclr  input  1  asynchronous, active-high reset; shared with the downstream MAC.
REQ-004 in_valid/in_ready  input/output  1/1  operand-pair stream handshake; a pair is accepted when both are 1 at a clk edge.
REQ-005 in_a, in_b  input  8/8  signed operand pair.
REQ-006 in_last  input  1  marks the final pair of a dot-product vector.
REQ-007 mac_dataa, mac_datab  output  8/8  operands to the MAC.
REQ-008 mac_sload, mac_clken  output  1/1  MAC load-new-sum and clock enable.
REQ-009 mac_result  input  18  signed MAC accumulator output.
REQ-010 out_valid/out_ready  output/input  1/1  result handshake; transfer when both are 1 at an edge.
REQ-011 out_data  output  18  signed captured dot product.
REQ-012 out_count  output  3  number of pairs in the captured vector (1..7).
REQ-013 out_trunc  output  1  vector ended by the length limit, not by in_last.

Function
REQ-014 accept = in_valid & in_ready; mac_dataa/mac_datab SHALL equal in_a/in_b when accept=1, else 0 (combinational).
REQ-015 mac_sload SHALL be 1 exactly when accept=1 and the pair is the first of a vector; else 0.
REQ-016 mac_clken SHALL be accept | t1_valid, where t1 is the internal tag stage {valid, last} loaded on each edge with clken=1.
REQ-017 MAC latency: a pair presented at edge E0 is included in mac_result after edge E1; t1 SHALL model E0 and a capture-pending flag SHALL be set at E1 when t1.last=1 and clken=1.
REQ-018 When capture-pending=1, the next edge SHALL load out_data<=mac_result, out_count, and out_trunc; set out_valid=1; and clear capture-pending.
REQ-019 A pair counter (3 bit) SHALL increment per accepted pair and return to 0 after a last pair; the 7th accepted pair SHALL be treated as last whatever in_last is, setting out_trunc=1 if in_last=0.
REQ-020 in_ready SHALL be 0 while out_valid=1, t1.last=1, or capture-pending=1; otherwise 1. Only one vector is in flight or held at a time.
REQ-021 Gaps mid-vector (in_valid=0) SHALL present 0/0 operands with sload=0, leaving the accumulator sum unchanged.
REQ-022 out_valid SHALL clear on the edge where out_ready=1; out_data, out_count and out_trunc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Arithmetic: maximum magnitude is 7*16384=114688, which fits 18 bit signed; no saturation logic.
REQ-024 A single-pair vector (first and last) SHALL produce sload=1 and be captured normally with out_count=1.

Reset
REQ-025 aclr=1 SHALL immediately clear t1, capture-pending, the pair counter, out_valid, out_data, out_count and out_trunc to 0.
REQ-026 While aclr=1, mac_clken, mac_sload and in_ready SHALL be 0; in_ready SHALL be 1 on the first edge after deassertion.
REQ-027 A reset mid-vector SHALL discard the partial vector; the next accepted pair SHALL be a first pair (sload=1).

Verification
REQ-028 Pairs (3,4),(-2,5),(7,7 last), back-to-back -> out_data=51, out_count=3, out_trunc=0, out_valid rises 2 edges after the last accept.
REQ-029 7 pairs (-128,-128), in_last=0 throughout -> out_data=114688, out_count=7, out_trunc=1; the next pair asserts sload=1.
REQ-030 Vector (5,5),gap 3 cycles,(-1,10 last) -> out_data=15, mac_clken=0 during idle gap cycles after t1 drains.
REQ-031 out_ready=0 for 10 cycles after result -> in_ready=0, out_data stable; the next vector (1,1 last) is accepted after out_ready=1 and gives out_data=1.
REQ-032 aclr pulse after 2 pairs of a vector -> all outputs 0; new vector (2,-3 last) gives out_data=-6, out_count=1.
